// File: rtl/oh_memory_bist.sv
// oh_memory_bist: March C- BIST controller for a 1-cycle synchronous-read memory,
// with sticky fail flag, first-fail address capture and saturating fail count.
module oh_memory_bist #(
  parameter int DW    = 104,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          bist_en,
  output logic          bist_we,
  output logic [DW-1:0] bist_wem,
  output logic [AW-1:0] bist_addr,
  output logic [DW-1:0] bist_din,
  input  logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [CW-1:0] fail_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [AW-1:0] last_addr = AW'(DEPTH - 1);
  state_t state, state_nxt;
  logic [2:0] elem, elem_nxt;
  logic phase, phase_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic cmp_vld, cmp_exp;
  logic [AW-1:0] cmp_addr;
  logic go, up, is_wr, rd_pat, wr_pat, addr_done, elem_end, mismatch;
  assign go        = (state == IDLE || state == DONE) && start;
  assign up        = elem < 3'd3;
  // M0 is write-only; in M1-M4 phase selects read (0) or write (1); M5 is read-only
  assign is_wr     = elem == 3'd0 || phase;
  assign rd_pat    = elem == 3'd2 || elem == 3'd4;
  assign wr_pat    = elem == 3'd1 || elem == 3'd3;
  assign addr_done = is_wr || elem == 3'd5;
  assign elem_end  = addr == (up ? last_addr : '0);
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    phase_nxt = phase;
    addr_nxt  = addr;
    if (go) begin
      state_nxt = RUN;
      elem_nxt  = '0;
      phase_nxt = 1'b0;
      addr_nxt  = '0;
    end else if (state == RUN) begin
      if (!addr_done) phase_nxt = 1'b1;
      else begin
        phase_nxt = 1'b0;
        if (!elem_end) addr_nxt = up ? addr + AW'(1) : addr - AW'(1);
        else if (elem == 3'd5) state_nxt = DRAIN;
        else begin
          elem_nxt = elem + 3'd1;
          addr_nxt = elem < 3'd2 ? '0 : last_addr;
        end
      end
    end else if (state == DRAIN) state_nxt = DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      elem  <= '0;
      phase <= 1'b0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
      phase <= phase_nxt;
      addr  <= addr_nxt;
    end
  end
  assign mismatch = cmp_vld && dout != {DW{cmp_exp}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_vld    <= 1'b0;
      cmp_exp    <= 1'b0;
      cmp_addr   <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else begin
      cmp_vld  <= state == RUN && !is_wr;
      cmp_exp  <= rd_pat;
      cmp_addr <= addr;
      if (go) begin
        fail       <= 1'b0;
        fail_addr  <= '0;
        fail_count <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= cmp_addr;
        if (fail_count != {CW{1'b1}}) fail_count <= fail_count + CW'(1);
      end
    end
  end
  assign bist_en   = state == RUN;
  assign bist_we   = bist_en && is_wr;
  assign bist_wem  = bist_we ? {DW{1'b1}} : '0;
  assign bist_din  = (bist_we && wr_pat) ? {DW{1'b1}} : '0;
  assign bist_addr = bist_en ? addr : '0;
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
endmodule

// File: tb/tb_oh_memory_bist.sv
// tb_oh_memory_bist: scoreboard bench for oh_memory_bist; a March C- reference model
// queues expected accesses and results, and a negedge monitor pops and compares.
module tb_oh_memory_bist;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start_a, start_b;
  logic a_en, a_we, a_busy, a_done, a_fail;
  logic [15:0] a_wem, a_din, a_dout;
  logic [2:0] a_addr, a_faddr;
  logic [7:0] a_fcnt;
  logic b_en, b_we, b_busy, b_done, b_fail;
  logic [7:0] b_wem, b_din, b_dout;
  logic [2:0] b_addr, b_faddr;
  logic [1:0] b_fcnt;
  oh_memory_bist #(.DW(16), .DEPTH(8), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bist_en(a_en), .bist_we(a_we),
    .bist_wem(a_wem), .bist_addr(a_addr), .bist_din(a_din), .dout(a_dout),
    .busy(a_busy), .done(a_done), .fail(a_fail), .fail_addr(a_faddr), .fail_count(a_fcnt));
  oh_memory_bist #(.DW(8), .DEPTH(6), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bist_en(b_en), .bist_we(b_we),
    .bist_wem(b_wem), .bist_addr(b_addr), .bist_din(b_din), .dout(b_dout),
    .busy(b_busy), .done(b_done), .fail(b_fail), .fail_addr(b_faddr), .fail_count(b_fcnt));

  typedef struct {bit we; int addr; int din; int wem;} acc_t;
  typedef struct {bit f; int fa; int fc; int s; int lat;} res_t;
  acc_t qa[$], qb[$];
  res_t ra[$], rb[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int len[2], last[2];
  bit dq[2];
  bit af_on, af_val, bf_on, bf_val, bf_all;
  int af_addr, af_bit, bf_addr, bf_bit;
  // March C- as a table: ops per element, write/read flag, data value, direction
  int n_ops[6]    = '{1, 2, 2, 2, 2, 1};
  bit op_wr[6][2] = '{'{1,0}, '{0,1}, '{0,1}, '{0,1}, '{0,1}, '{0,0}};
  bit op_v[6][2]  = '{'{0,0}, '{0,1}, '{1,0}, '{0,1}, '{1,0}, '{0,0}};
  bit up_e[6]     = '{1, 1, 1, 0, 0, 0};
  logic [15:0] mem_a[8];
  logic [7:0] mem_b[8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int faulty(int r, int a, int ones, bit on, int fa, int fb, bit fv, bit all);
    if (all) return ones;
    if (on && a == fa) return fv ? (r | (1 << fb)) : (r & ~(1 << fb));
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_a[a_addr] <= (mem_a[a_addr] & ~a_wem) | (a_din & a_wem);
      else a_dout <= 16'(faulty(int'(mem_a[a_addr]), int'(a_addr), 16'hffff, af_on, af_addr, af_bit, af_val, 1'b0));
    end
    if (b_en) begin
      if (b_we) mem_b[b_addr] <= (mem_b[b_addr] & ~b_wem) | (b_din & b_wem);
      else b_dout <= 8'(faulty(int'(mem_b[b_addr]), int'(b_addr), 8'hff, bf_on, bf_addr, bf_bit, bf_val, bf_all));
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic plan(input bit b, input int d, input int w, input int cmax, input bit on,
                      input int fa, input int fb, input bit fv, input bit all, input int s);
    int m[8];
    int ones, nf, first, a, v;
    acc_t x;
    res_t r;
    ones = (1 << w) - 1;
    nf = 0;
    first = 0;
    foreach (m[i]) m[i] = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < d; i++) begin
        a = up_e[e] ? i : d - 1 - i;
        for (int k = 0; k < n_ops[e]; k++) begin
          v = op_v[e][k] ? ones : 0;
          x.we = op_wr[e][k];
          x.addr = a;
          x.din = x.we ? v : 0;
          x.wem = x.we ? ones : 0;
          if (b) qb.push_back(x); else qa.push_back(x);
          if (x.we) m[a] = v;
          else if (faulty(m[a], a, ones, on, fa, fb, fv, all) != v) begin
            if (nf == 0) first = a;
            nf++;
          end
        end
      end
    r.f = nf > 0;
    r.fa = first;
    r.fc = nf > cmax ? cmax : nf;
    r.s = s;
    r.lat = 10 * d + 2;
    if (b) rb.push_back(r); else ra.push_back(r);
  endtask

  task automatic mon(input bit b, input bit en, input bit we, input int wem, input int addr,
                     input int din, input bit busy, input bit done, input bit fl, input int fa, input int fc);
    acc_t x;
    res_t r;
    string p;
    p = b ? "b" : "a";
    if (en) begin
      len[b]++;
      if ((b ? qb.size() : qa.size()) == 0) check({p, "_unexpected_access"}, 1, 0);
      else begin
        if (b) x = qb.pop_front(); else x = qa.pop_front();
        check({p, "_we"}, int'(we), int'(x.we));
        check({p, "_addr"}, addr, x.addr);
        check({p, "_wem"}, wem, x.wem);
        if (x.we) check({p, "_din"}, din, x.din);
      end
    end else begin
      if (len[b] > 0) last[b] = len[b];
      len[b] = 0;
      check({p, "_idle_bus_zero"}, addr | din | wem, 0);
    end
    if (done && !dq[b]) begin
      if ((b ? rb.size() : ra.size()) == 0) check({p, "_unexpected_done"}, 1, 0);
      else begin
        if (b) r = rb.pop_front(); else r = ra.pop_front();
        check({p, "_fail"}, int'(fl), int'(r.f));
        check({p, "_fail_addr"}, fa, r.fa);
        check({p, "_fail_count"}, fc, r.fc);
        check({p, "_done_latency"}, cyc - r.s + 1, r.lat);
        check({p, "_run_length"}, last[b], r.lat - 2);
        check({p, "_busy_in_done"}, int'(busy), 0);
      end
    end
    dq[b] = done;
  endtask

  always @(negedge clk) begin
    mon(1'b0, a_en, a_we, int'(a_wem), int'(a_addr), int'(a_din), a_busy, a_done, a_fail, int'(a_faddr), int'(a_fcnt));
    mon(1'b1, b_en, b_we, int'(b_wem), int'(b_addr), int'(b_din), b_busy, b_done, b_fail, int'(b_faddr), int'(b_fcnt));
  end

  task automatic run(input bit b);
    @(negedge clk);
    if (b) plan(1'b1, 6, 8, 3, bf_on, bf_addr, bf_bit, bf_val, bf_all, cyc + 1);
    else plan(1'b0, 8, 16, 255, af_on, af_addr, af_bit, af_val, 1'b0, cyc + 1);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b);
    int n;
    n = 0;
    while ((b ? rb.size() : ra.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(b ? "b_timeout" : "a_timeout", int'((b ? rb.size() : ra.size()) != 0), 0);
    check(b ? "b_leftover_access" : "a_leftover_access", b ? qb.size() : qa.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    {af_on, af_val, bf_on, bf_val, bf_all} = '0;
    {af_addr, af_bit, bf_addr, bf_bit} = '0;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", int'({a_en, a_we, a_busy, a_done, a_fail, a_faddr, a_fcnt}), 0);
    check("b_reset_outputs", int'({b_en, b_we, b_busy, b_done, b_fail, b_faddr, b_fcnt}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("a_idle_after_reset", int'({a_en, a_busy, a_done}), 0);
    run(1'b0);
    wait_done(1'b0);
    check("a_good_fail_count", int'(a_fcnt), 0);
    af_on = 1'b1; af_addr = 5; af_bit = 0; af_val = 1'b1;
    run(1'b0);
    wait_done(1'b0);
    check("a_stuck1_fail", int'(a_fail), 1);
    check("a_stuck1_fail_addr", int'(a_faddr), 5);
    check("a_stuck1_fail_count", int'(a_fcnt), 3);
    af_on = 1'b0;
    run(1'b0);
    check("a_restart_clears_fail", int'(a_fail), 0);
    check("a_restart_clears_count", int'(a_fcnt), 0);
    check("a_restart_busy", int'({a_busy, a_done}), 2);
    repeat (37) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0);
    for (int t = 0; t < 6; t++) begin
      af_on = 1'($urandom_range(0, 1));
      af_addr = $urandom_range(0, 7);
      af_bit = $urandom_range(0, 15);
      af_val = 1'($urandom_range(0, 1));
      run(1'b0);
      wait_done(1'b0);
    end
    af_on = 1'b0;
    run(1'b0);
    repeat (27) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("a_async_reset_en", int'(a_en), 0);
    check("a_async_reset_busy", int'(a_busy), 0);
    qa.delete();
    ra.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("a_no_access_after_reset", int'({a_en, a_busy}), 0);
    end
    run(1'b0);
    wait_done(1'b0);
    run(1'b1);
    wait_done(1'b1);
    bf_all = 1'b1;
    run(1'b1);
    wait_done(1'b1);
    check("b_saturated_count", int'(b_fcnt), 3);
    check("b_saturated_fail_addr", int'(b_faddr), 0);
    bf_all = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bf_on = 1'b1;
      bf_addr = $urandom_range(0, 5);
      bf_bit = $urandom_range(0, 7);
      bf_val = 1'($urandom_range(0, 1));
      run(1'b1);
      wait_done(1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
